ram_arbiter_rr: RTL and testbench

RAM_ARBITER_RR -- requirements
Module: ram_arbiter_rr

---
 rtl/ram_arbiter_rr.sv | 183 ++++++++++++++++++
 tb/tb_ram_arbiter_rr.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_rr.sv
// rtl/ram_arbiter_rr.sv - two-port round-robin arbiter in front of a simple dual-port RAM, with fill sweep
//
// Purpose:
//   Arbitrates single-beat read/write requests from requesters A and B onto one
//   RAM command interface (one command per cycle at most). An init pulse
//   starts a fill sweep that writes fill_val to every RAM location.
//
// Ports:
//   clk                 single clock (RAM wr_clk/rd_clk are tied to it)
//   clr                 synchronous active-high reset
//   init, fill_val      start a fill sweep / data written by the sweep
//   x_req/x_we/x_add/x_din  requester x access (held until x_gnt)
//   x_gnt               one-cycle grant pulse, cycle after arbitration
//   x_rvalid            read data for requester x valid on rd_data
//   rd_data             combinational copy of ram_d_out
//   busy                fill sweep in progress
//   ram_*               RAM command/data interface (registered commands)

module ram_arbiter_rr #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          init,
  input  logic [DW-1:0] fill_val,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_add,
  input  logic [DW-1:0] a_din,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_add,
  input  logic [DW-1:0] b_din,
  output logic          a_gnt,
  output logic          b_gnt,
  output logic          a_rvalid,
  output logic          b_rvalid,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          ram_we,
  output logic          ram_re,
  output logic [AW-1:0] ram_wr_add,
  output logic [AW-1:0] ram_rd_add,
  output logic [DW-1:0] ram_d_in,
  input  logic [DW-1:0] ram_d_out
);

  typedef enum logic {ST_RUN, ST_INIT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_b_q, last_b_d;       // 1: B was granted last
  logic          rd_owner_b_q, rd_owner_b_d; // owner of the read command on the RAM
  logic          a_gnt_q, a_gnt_d;
  logic          b_gnt_q, b_gnt_d;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;
  logic          busy_q, busy_d;
  logic          ram_we_q, ram_we_d;
  logic          ram_re_q, ram_re_d;
  logic [AW-1:0] ram_wr_add_q, ram_wr_add_d;
  logic [AW-1:0] ram_rd_add_q, ram_rd_add_d;
  logic [DW-1:0] ram_d_in_q, ram_d_in_d;

  logic          a_elig, b_elig, pick_b, sel_we;
  logic [AW-1:0] sel_add;
  logic [DW-1:0] sel_din;

  // A requester whose grant pulse is still showing cannot win again at this edge,
  // which is what gives a lone requester one command every second cycle.
  assign a_elig = a_req && !a_gnt_q;
  assign b_elig = b_req && !b_gnt_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_b_d     = last_b_q;
    rd_owner_b_d = rd_owner_b_q;
    a_gnt_d      = 1'b0;
    b_gnt_d      = 1'b0;
    busy_d       = 1'b0;
    ram_we_d     = 1'b0;
    ram_re_d     = 1'b0;
    ram_wr_add_d = ram_wr_add_q;
    ram_rd_add_d = ram_rd_add_q;
    ram_d_in_d   = ram_d_in_q;
    // The RAM returns read data one edge after the read command, whatever the
    // FSM does meanwhile, so a read issued just before a sweep still completes.
    a_rvalid_d   = ram_re_q && !rd_owner_b_q;
    b_rvalid_d   = ram_re_q && rd_owner_b_q;

    pick_b  = b_elig && (!a_elig || !last_b_q);
    sel_we  = pick_b ? b_we  : a_we;
    sel_add = pick_b ? b_add : a_add;
    sel_din = pick_b ? b_din : a_din;

    case (state_q)
      ST_RUN: begin
        if (init) begin
          state_d      = ST_INIT;
          cnt_d        = '0;
          busy_d       = 1'b1;
          ram_we_d     = 1'b1;
          ram_wr_add_d = '0;
          ram_d_in_d   = fill_val;
        end else if (a_elig || b_elig) begin
          last_b_d = pick_b;
          a_gnt_d  = !pick_b;
          b_gnt_d  = pick_b;
          if (sel_we) begin
            ram_we_d     = 1'b1;
            ram_wr_add_d = sel_add;
            ram_d_in_d   = sel_din;
          end else begin
            ram_re_d     = 1'b1;
            ram_rd_add_d = sel_add;
            rd_owner_b_d = pick_b;
          end
        end
      end
      ST_INIT: begin
        // cnt_q is the address being written in the current cycle; init is ignored here.
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == {AW{1'b1}}) begin
          state_d = ST_RUN;
        end else begin
          busy_d       = 1'b1;
          ram_we_d     = 1'b1;
          ram_wr_add_d = cnt_q + AW'(1);
          ram_d_in_d   = fill_val;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      last_b_q     <= 1'b1;  // A wins the first tie after reset
      rd_owner_b_q <= 1'b0;
      a_gnt_q      <= 1'b0;
      b_gnt_q      <= 1'b0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      busy_q       <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_re_q     <= 1'b0;
      ram_wr_add_q <= '0;
      ram_rd_add_q <= '0;
      ram_d_in_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_b_q     <= last_b_d;
      rd_owner_b_q <= rd_owner_b_d;
      a_gnt_q      <= a_gnt_d;
      b_gnt_q      <= b_gnt_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      busy_q       <= busy_d;
      ram_we_q     <= ram_we_d;
      ram_re_q     <= ram_re_d;
      ram_wr_add_q <= ram_wr_add_d;
      ram_rd_add_q <= ram_rd_add_d;
      ram_d_in_q   <= ram_d_in_d;
    end
  end

  assign a_gnt      = a_gnt_q;
  assign b_gnt      = b_gnt_q;
  assign a_rvalid   = a_rvalid_q;
  assign b_rvalid   = b_rvalid_q;
  assign busy       = busy_q;
  assign ram_we     = ram_we_q;
  assign ram_re     = ram_re_q;
  assign ram_wr_add = ram_wr_add_q;
  assign ram_rd_add = ram_rd_add_q;
  assign ram_d_in   = ram_d_in_q;
  assign rd_data    = ram_d_out;

endmodule

// File: tb/tb_ram_arbiter_rr.sv
// tb/tb_ram_arbiter_rr.sv - self-checking bench for ram_arbiter_rr

module tb_ram_arbiter_rr;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NV = 19;

  logic          clk = 1'b0;
  logic          clr, init;
  logic [DW-1:0] fill_val;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_add, b_add;
  logic [DW-1:0] a_din, b_din;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, busy;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_wr_add, ram_rd_add;
  logic [DW-1:0] ram_d_in, ram_d_out, rd_data;

  always #5 clk = ~clk;

  ram_arbiter_rr #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .clr(clr), .init(init), .fill_val(fill_val),
    .a_req(a_req), .a_we(a_we), .a_add(a_add), .a_din(a_din),
    .b_req(b_req), .b_we(b_we), .b_add(b_add), .b_din(b_din),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .rd_data(rd_data), .busy(busy), .ram_we(ram_we), .ram_re(ram_re),
    .ram_wr_add(ram_wr_add), .ram_rd_add(ram_rd_add), .ram_d_in(ram_d_in),
    .ram_d_out(ram_d_out)
  );

  // Synchronous RAM attached to the command interface.
  logic [DW-1:0] mem [8];
  always @(posedge clk) begin
    if (ram_we) mem[ram_wr_add] <= ram_d_in;
    if (ram_re) ram_d_out <= mem[ram_rd_add];
  end

  typedef struct {
    logic          a_req, a_we;
    logic [AW-1:0] a_add;
    logic [DW-1:0] a_din;
    logic          b_req, b_we;
    logic [AW-1:0] b_add;
    logic [DW-1:0] b_din;
    logic          exp_a_gnt, exp_b_gnt;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  vec_t          vecs [NV];
  rd_exp_t       a_q[$], b_q[$];
  logic [DW-1:0] ref_mem [8];
  logic [AW-1:0] exp_wr_add, exp_rd_add;
  logic [DW-1:0] exp_d_in;
  int            checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon();
    rd_exp_t e;
    if (a_rvalid) begin
      if (a_q.size() == 0) chk("a_rvalid_unexpected", 32'(a_rvalid), 32'(0));
      else begin
        e = a_q.pop_front();
        chk("a_rd_data", 32'(rd_data), 32'(e.data));
        chk("a_rvalid_cycle", 32'(cyc), 32'(e.due));
      end
    end
    if (b_rvalid) begin
      if (b_q.size() == 0) chk("b_rvalid_unexpected", 32'(b_rvalid), 32'(0));
      else begin
        e = b_q.pop_front();
        chk("b_rd_data", 32'(rd_data), 32'(e.data));
        chk("b_rvalid_cycle", 32'(cyc), 32'(e.due));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mon();
  endtask

  task automatic push_rd(input bit use_b, input logic [AW-1:0] add, input int due);
    rd_exp_t e;
    e.data = ref_mem[add];
    e.due  = due;
    if (use_b) b_q.push_back(e);
    else       a_q.push_back(e);
  endtask

  // Record the effect of a command the arbiter is expected to issue.
  task automatic issue(input bit use_b, input logic we, input logic [AW-1:0] add,
                       input logic [DW-1:0] din, input int due);
    if (we) begin
      ref_mem[add] = din;
      exp_wr_add   = add;
      exp_d_in     = din;
    end else begin
      push_rd(use_b, add, due);
      exp_rd_add = add;
    end
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_add = '0; a_din = '0;
    b_req = 0; b_we = 0; b_add = '0; b_din = '0;
    init = 0;
  endtask

  task automatic do_read(input bit use_b, input logic [AW-1:0] add);
    bit got;
    got = 0;
    if (use_b) begin b_req = 1; b_we = 0; b_add = add; end
    else       begin a_req = 1; a_we = 0; a_add = add; end
    for (int t = 0; t < 20 && !got; t++) begin
      tick();
      if (use_b ? b_gnt : a_gnt) begin
        got = 1;
        push_rd(use_b, add, cyc + 1);
      end
    end
    a_req = 0; b_req = 0;
    chk("read_grant_seen", 32'(got), 32'(1));
    tick();
    tick();
  endtask

  function automatic vec_t mk(input logic ar, input logic aw, input logic [AW-1:0] aa,
                              input logic [DW-1:0] ad, input logic br, input logic bw,
                              input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                              input logic ea, input logic eb);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_add = aa; v.a_din = ad;
    v.b_req = br; v.b_we = bw; v.b_add = ba; v.b_din = bd;
    v.exp_a_gnt = ea; v.exp_b_gnt = eb;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Tie after reset goes to A; lone requesters alternate with idle cycles;
    // two held requesters alternate every cycle.
    vecs[0]  = mk(1, 1, 3, 16'hBEEF, 1, 1, 6, 16'h6666, 1, 0);
    vecs[1]  = mk(1, 0, 3, 16'h0000, 1, 1, 6, 16'h6666, 0, 1);
    vecs[2]  = mk(1, 0, 3, 16'h0000, 0, 0, 0, 16'h0000, 1, 0);
    vecs[3]  = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    vecs[4]  = mk(1, 1, 1, 16'h1111, 1, 1, 2, 16'h2222, 0, 1);
    vecs[5]  = mk(1, 1, 1, 16'h1111, 1, 0, 2, 16'h0000, 1, 0);
    vecs[6]  = mk(1, 0, 1, 16'h0000, 1, 0, 2, 16'h0000, 0, 1);
    vecs[7]  = mk(1, 0, 1, 16'h0000, 1, 0, 2, 16'h0000, 1, 0);
    vecs[8]  = mk(1, 0, 1, 16'h0000, 1, 0, 2, 16'h0000, 0, 1);
    vecs[9]  = mk(1, 0, 1, 16'h0000, 1, 0, 2, 16'h0000, 1, 0);
    vecs[10] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    vecs[11] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    vecs[12] = mk(1, 0, 3, 16'h0000, 0, 0, 0, 16'h0000, 1, 0);
    vecs[13] = mk(1, 0, 3, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    vecs[14] = mk(1, 0, 3, 16'h0000, 0, 0, 0, 16'h0000, 1, 0);
    vecs[15] = mk(1, 0, 3, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    vecs[16] = mk(0, 0, 0, 16'h0000, 1, 0, 6, 16'h0000, 0, 1);
    vecs[17] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    vecs[18] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);

    // Reset
    idle_inputs();
    fill_val = '0;
    clr = 1;
    tick();
    tick();
    chk("rst_a_gnt", 32'(a_gnt), 0);
    chk("rst_b_gnt", 32'(b_gnt), 0);
    chk("rst_a_rvalid", 32'(a_rvalid), 0);
    chk("rst_b_rvalid", 32'(b_rvalid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_re", 32'(ram_re), 0);
    chk("rst_wr_add", 32'(ram_wr_add), 0);
    chk("rst_rd_add", 32'(ram_rd_add), 0);
    chk("rst_d_in", 32'(ram_d_in), 0);
    clr = 0;
    exp_wr_add = '0; exp_rd_add = '0; exp_d_in = '0;

    // Table-driven arbitration
    for (int i = 0; i < NV; i++) begin
      logic ew, er;
      a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_add = vecs[i].a_add; a_din = vecs[i].a_din;
      b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_add = vecs[i].b_add; b_din = vecs[i].b_din;
      ew = (vecs[i].exp_a_gnt && vecs[i].a_we) || (vecs[i].exp_b_gnt && vecs[i].b_we);
      er = (vecs[i].exp_a_gnt && !vecs[i].a_we) || (vecs[i].exp_b_gnt && !vecs[i].b_we);
      if (vecs[i].exp_a_gnt) issue(0, vecs[i].a_we, vecs[i].a_add, vecs[i].a_din, cyc + 2);
      if (vecs[i].exp_b_gnt) issue(1, vecs[i].b_we, vecs[i].b_add, vecs[i].b_din, cyc + 2);
      tick();
      chk($sformatf("v%0d_a_gnt", i), 32'(a_gnt), 32'(vecs[i].exp_a_gnt));
      chk($sformatf("v%0d_b_gnt", i), 32'(b_gnt), 32'(vecs[i].exp_b_gnt));
      chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(ew));
      chk($sformatf("v%0d_ram_re", i), 32'(ram_re), 32'(er));
      chk($sformatf("v%0d_wr_add", i), 32'(ram_wr_add), 32'(exp_wr_add));
      chk($sformatf("v%0d_rd_add", i), 32'(ram_rd_add), 32'(exp_rd_add));
      chk($sformatf("v%0d_d_in", i), 32'(ram_d_in), 32'(exp_d_in));
      chk($sformatf("v%0d_busy", i), 32'(busy), 0);
    end

    // Read granted just before a fill sweep; B waits through the sweep.
    idle_inputs();
    a_req = 1; a_we = 0; a_add = 3;
    push_rd(0, 3, cyc + 2);
    tick();
    chk("pre_init_a_gnt", 32'(a_gnt), 1);
    chk("pre_init_ram_re", 32'(ram_re), 1);
    a_req = 0;
    b_req = 1; b_we = 0; b_add = 5;
    init = 1; fill_val = 16'h00A5;
    tick();
    chk("init0_busy", 32'(busy), 1);
    chk("init0_b_gnt", 32'(b_gnt), 0);
    chk("init0_ram_we", 32'(ram_we), 1);
    chk("init0_wr_add", 32'(ram_wr_add), 0);
    chk("init0_d_in", 32'(ram_d_in), 32'(16'h00A5));
    for (int k = 1; k < 8; k++) begin
      init = (k < 3);
      tick();
      chk($sformatf("init%0d_busy", k), 32'(busy), 1);
      chk($sformatf("init%0d_b_gnt", k), 32'(b_gnt), 0);
      chk($sformatf("init%0d_ram_we", k), 32'(ram_we), 1);
      chk($sformatf("init%0d_ram_re", k), 32'(ram_re), 0);
      chk($sformatf("init%0d_wr_add", k), 32'(ram_wr_add), 32'(k));
    end
    init = 0;
    for (int k = 0; k < 8; k++) ref_mem[k] = 16'h00A5;
    tick();
    chk("init_done_busy", 32'(busy), 0);
    chk("init_done_ram_we", 32'(ram_we), 0);
    chk("init_done_b_gnt", 32'(b_gnt), 0);
    push_rd(1, 5, cyc + 2);
    tick();
    chk("post_init_b_gnt", 32'(b_gnt), 1);
    chk("post_init_ram_re", 32'(ram_re), 1);
    chk("post_init_rd_add", 32'(ram_rd_add), 5);
    b_req = 0;
    tick();
    tick();
    do_read(0, 0);
    do_read(1, 7);
    do_read(0, 3);

    // Reset in the middle of a sweep: addresses 0..3 filled, 4..7 keep the old fill.
    init = 1; fill_val = 16'h5A5A;
    tick();
    init = 0;
    tick(); tick(); tick();
    chk("sweep_wr_add_3", 32'(ram_wr_add), 3);
    clr = 1;
    tick();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ram_we", 32'(ram_we), 0);
    chk("abort_wr_add", 32'(ram_wr_add), 0);
    chk("abort_d_in", 32'(ram_d_in), 0);
    chk("abort_a_gnt", 32'(a_gnt), 0);
    clr = 0;
    for (int k = 0; k < 4; k++) ref_mem[k] = 16'h5A5A;

    // First tie after reset goes to A, then B.
    a_req = 1; a_we = 0; a_add = 0;
    b_req = 1; b_we = 0; b_add = 4;
    push_rd(0, 0, cyc + 2);
    tick();
    chk("tie_a_gnt", 32'(a_gnt), 1);
    chk("tie_b_gnt", 32'(b_gnt), 0);
    a_req = 0;
    push_rd(1, 4, cyc + 2);
    tick();
    chk("tie2_b_gnt", 32'(b_gnt), 1);
    b_req = 0;
    tick(); tick(); tick();
    for (int k = 1; k < 8; k++) begin
      if (k != 4) do_read(k[0], 3'(k));
    end

    chk("a_q_drained", 32'(a_q.size()), 0);
    chk("b_q_drained", 32'(b_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
